seq_controller: RTL and testbench

- Stage sequencer for the single-cycle-per-stage Y86-64 SEQ datapath.
- Replaces free-running clock/PC timing with explicit one-hot stage enables: fetch, decode, execute, memory, writeback, PC update.
- Adds a memory-ready handshake with timeout, Y86 status (AOK/HLT/ADR/INS) tracking, run/single-step control, and cycle/instruction counters.
- Sits between the testbench/top level and the six stage modules.

---
 rtl/seq_controller_if.sv | 36 +++
 rtl/seq_controller.sv | 126 ++++++++++++
 tb/tb_seq_controller.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_controller_if.sv
// Run-control and stage-status bundle between the SEQ top level and its stage sequencer.
// The top level drives run control and fetch/memory status; the sequencer drives enables, status and counters.
interface seq_controller_if #(
   parameter int CNT_W = 32
);
   logic             go;
   logic             step_mode;
   logic             hlt;
   logic             imem_error;
   logic             instr_valid;
   logic             mem_ready;
   logic             dmem_error;
   logic             fetch_en;
   logic             decode_en;
   logic             execute_en;
   logic             memory_en;
   logic             writeback_en;
   logic             pc_we;
   logic [2:0]       stat;
   logic             busy;
   logic             halted;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output go, step_mode, hlt, imem_error, instr_valid, mem_ready, dmem_error,
      input  fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_we,
      input  stat, busy, halted, cycle_count, instr_count
   );

   modport slave (
      input  go, step_mode, hlt, imem_error, instr_valid, mem_ready, dmem_error,
      output fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_we,
      output stat, busy, halted, cycle_count, instr_count
   );
endinterface

// File: rtl/seq_controller.sv
// One-hot stage sequencer for the Y86-64 SEQ datapath with Y86 status tracking and run counters.
// Latency 6 cycles/instr minimum; mem_ready low stalls MEMORY, MEM_TIMEOUT stalled cycles fault to ADR.
module seq_controller #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input logic             clk,
   input logic             rst,
   seq_controller_if.slave ctl
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_PCUPDATE,
      S_HALTED
   } state_t;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [2:0]        stat_q, stat_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
   logic [CNT_W-1:0]  instr_count_q, instr_count_d;
   logic              busy;
   logic              fetch_fault;

   assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign fetch_fault = ctl.imem_error | ~ctl.instr_valid | ctl.hlt;

   always_comb begin
      state_d       = state_q;
      stat_d        = stat_q;
      wait_cnt_d    = '0;
      cycle_count_d = cycle_count_q;
      instr_count_d = instr_count_q;

      if (busy && (cycle_count_q != {CNT_W{1'b1}})) begin
         cycle_count_d = cycle_count_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (ctl.go) state_d = S_FETCH;
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (ctl.imem_error) begin
               state_d = S_HALTED;
               stat_d  = STAT_ADR;
            end else if (!ctl.instr_valid) begin
               state_d = S_HALTED;
               stat_d  = STAT_INS;
            end else if (ctl.hlt) begin
               state_d = S_HALTED;
               stat_d  = STAT_HLT;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: state_d = S_MEMORY;
         S_MEMORY: begin
            // A completing access takes priority over the timeout on the same cycle.
            if (ctl.mem_ready) begin
               if (ctl.dmem_error) begin
                  state_d = S_HALTED;
                  stat_d  = STAT_ADR;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_HALTED;
               stat_d  = STAT_ADR;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         S_WRITEBACK: state_d = S_PCUPDATE;
         S_PCUPDATE: begin
            instr_count_d = instr_count_q + CNT_W'(1);
            state_d       = ctl.step_mode ? S_IDLE : S_FETCH;
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         stat_q        <= STAT_AOK;
         wait_cnt_q    <= '0;
         cycle_count_q <= '0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         stat_q        <= stat_d;
         wait_cnt_q    <= wait_cnt_d;
         cycle_count_q <= cycle_count_d;
         instr_count_q <= instr_count_d;
      end
   end

   // A faulting fetch must not let decode read the register file.
   assign ctl.fetch_en     = (state_q == S_FETCH);
   assign ctl.decode_en    = (state_q == S_DECODE) && !fetch_fault;
   assign ctl.execute_en   = (state_q == S_EXECUTE);
   assign ctl.memory_en    = (state_q == S_MEMORY);
   assign ctl.writeback_en = (state_q == S_WRITEBACK);
   assign ctl.pc_we        = (state_q == S_PCUPDATE);
   assign ctl.stat         = stat_q;
   assign ctl.busy         = busy;
   assign ctl.halted       = (state_q == S_HALTED);
   assign ctl.cycle_count  = cycle_count_q;
   assign ctl.instr_count  = instr_count_q;
endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench for seq_controller: an instruction-level model predicts every busy cycle's outputs.
module tb_seq_controller;
   localparam int CNT_W       = 8;
   localparam int MEM_TIMEOUT = 16;
   localparam int BUDGET      = 5000;

   localparam logic [5:0] EN_F = 6'b000001;
   localparam logic [5:0] EN_D = 6'b000010;
   localparam logic [5:0] EN_E = 6'b000100;
   localparam logic [5:0] EN_M = 6'b001000;
   localparam logic [5:0] EN_W = 6'b010000;
   localparam logic [5:0] EN_P = 6'b100000;

   typedef struct {
      bit imem;
      bit inv;
      bit hlt;
      int stall;
      bit derr;
   } instr_t;

   typedef struct packed {
      logic [5:0]       en;
      logic [2:0]       stat;
      logic [CNT_W-1:0] icnt;
      logic [CNT_W-1:0] ccnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   seq_controller_if #(.CNT_W(CNT_W)) ifc ();

   seq_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .ctl (ifc)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   bit         mon_en   = 1'b0;
   exp_t       exp_q[$];
   instr_t     prog[$];
   exp_t       mon_e;
   logic [2:0]       m_stat;
   logic             m_halted;
   logic [CNT_W-1:0] m_icnt;
   logic [CNT_W-1:0] m_ccnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [5:0] en_vec();
      return {ifc.pc_we, ifc.writeback_en, ifc.memory_en, ifc.execute_en, ifc.decode_en, ifc.fetch_en};
   endfunction

   function automatic instr_t mk(bit imem, bit inv, bit hlt, int stall, bit derr);
      instr_t t;
      t.imem = imem; t.inv = inv; t.hlt = hlt; t.stall = stall; t.derr = derr;
      return t;
   endfunction

   // Monitor: every busy cycle must match the next predicted cycle.
   always @(negedge clk) begin
      if (mon_en && (ifc.busy || (en_vec() != 6'd0))) begin
         if (exp_q.size() == 0) begin
            check("unexpected_busy", 32'(ifc.busy | (|en_vec())), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("enables", 32'(en_vec()), 32'(mon_e.en));
            check("busy", 32'(ifc.busy), 32'd1);
            check("halted_busy", 32'(ifc.halted), 32'd0);
            check("stat_busy", 32'(ifc.stat), 32'(mon_e.stat));
            check("icnt_busy", 32'(ifc.instr_count), 32'(mon_e.icnt));
            check("ccnt_busy", 32'(ifc.cycle_count), 32'(mon_e.ccnt));
         end
      end
   end

   task automatic push(input logic [5:0] en);
      exp_t e;
      e.en = en; e.stat = m_stat; e.icnt = m_icnt; e.ccnt = m_ccnt;
      exp_q.push_back(e);
      if (m_ccnt != {CNT_W{1'b1}}) m_ccnt = m_ccnt + 1'b1;
   endtask

   // Instruction-level reference: six stages, stalls stretch MEMORY, faults end the run.
   task automatic model_instr(input instr_t in);
      int mc;
      push(EN_F);
      if (in.imem || in.inv || in.hlt) begin
         push(6'd0);
         m_halted = 1'b1;
         m_stat   = in.imem ? 3'd3 : (in.inv ? 3'd4 : 3'd2);
         return;
      end
      push(EN_D);
      push(EN_E);
      mc = (in.stall >= MEM_TIMEOUT) ? MEM_TIMEOUT : in.stall + 1;
      repeat (mc) push(EN_M);
      if ((in.stall >= MEM_TIMEOUT) || in.derr) begin
         m_halted = 1'b1;
         m_stat   = 3'd3;
         return;
      end
      push(EN_W);
      push(EN_P);
      m_icnt = m_icnt + 1'b1;
   endtask

   task automatic do_reset();
      mon_en          = 1'b0;
      rst             = 1'b1;
      ifc.go          = 1'b0;
      ifc.step_mode   = 1'b0;
      ifc.hlt         = 1'b0;
      ifc.imem_error  = 1'b0;
      ifc.instr_valid = 1'b1;
      ifc.mem_ready   = 1'b0;
      ifc.dmem_error  = 1'b0;
      @(negedge clk);
      check("rst_enables", 32'(en_vec()), 32'd0);
      check("rst_stat", 32'(ifc.stat), 32'd1);
      check("rst_busy", 32'(ifc.busy), 32'd0);
      check("rst_halted", 32'(ifc.halted), 32'd0);
      check("rst_icnt", 32'(ifc.instr_count), 32'd0);
      check("rst_ccnt", 32'(ifc.cycle_count), 32'd0);
      #1;
      rst = 1'b0;
      exp_q.delete();
      prog.delete();
      m_stat   = 3'd1;
      m_halted = 1'b0;
      m_icnt   = '0;
      m_ccnt   = '0;
      mon_en   = 1'b1;
   endtask

   task automatic run_prog(input bit step);
      int     mi = 0;
      int     di = 0;
      int     mcnt = 0;
      int     cyc;
      bit     stop = 1'b0;
      instr_t cur;
      cur = mk(0, 0, 0, 0, 0);
      while (!stop) begin
         if (step) begin
            model_instr(prog[mi]);
            mi++;
         end else begin
            while ((mi < prog.size()) && !m_halted) begin
               model_instr(prog[mi]);
               mi++;
            end
         end
         ifc.go = 1'b1;
         cyc    = 0;
         do begin
            @(negedge clk);
            #1;
            ifc.go = 1'b0;
            cyc++;
            if (ifc.fetch_en) begin
               cur = (di < prog.size()) ? prog[di] : mk(0, 0, 0, 0, 0);
               ifc.imem_error  = cur.imem;
               ifc.instr_valid = !cur.inv;
               ifc.hlt         = cur.hlt;
               ifc.step_mode   = step || (di >= prog.size() - 1);
               di++;
               mcnt = 0;
            end
            if (ifc.memory_en) begin
               mcnt++;
               ifc.mem_ready  = (mcnt > cur.stall);
               ifc.dmem_error = ifc.mem_ready ? cur.derr : 1'($urandom_range(0, 1));
            end else begin
               ifc.mem_ready  = 1'($urandom_range(0, 1));
               ifc.dmem_error = 1'($urandom_range(0, 1));
            end
         end while (ifc.busy && (cyc < BUDGET));
         check("seg_done", 32'(ifc.busy), 32'd0);
         check("seg_halted", 32'(ifc.halted), 32'(m_halted));
         check("seg_stat", 32'(ifc.stat), 32'(m_stat));
         check("seg_icnt", 32'(ifc.instr_count), 32'(m_icnt));
         check("seg_ccnt", 32'(ifc.cycle_count), 32'(m_ccnt));
         check("seg_queue_left", 32'(exp_q.size()), 32'd0);
         stop = !step || m_halted || (mi >= prog.size());
      end
   endtask

   task automatic poke_go();
      ifc.go = 1'b1;
      @(negedge clk);
      #1;
      ifc.go = 1'b0;
      repeat (6) begin
         @(negedge clk);
         #1;
      end
      check("post_go_halted", 32'(ifc.halted), 32'(m_halted));
      check("post_go_stat", 32'(ifc.stat), 32'(m_stat));
      check("post_go_icnt", 32'(ifc.instr_count), 32'(m_icnt));
   endtask

   initial begin
      int n;
      int st;
      int cyc;
      rst = 1'b1;
      do_reset();

      // Three plain instructions back to back.
      repeat (3) prog.push_back(mk(0, 0, 0, 0, 0));
      run_prog(1'b0);
      check("t1_icnt", 32'(ifc.instr_count), 32'd3);
      check("t1_ccnt", 32'(ifc.cycle_count), 32'd18);
      check("t1_stat", 32'(ifc.stat), 32'd1);

      // Halt on the third fetch, then a go that must be ignored.
      do_reset();
      prog.push_back(mk(0, 0, 0, 0, 0));
      prog.push_back(mk(0, 0, 0, 0, 0));
      prog.push_back(mk(0, 0, 1, 0, 0));
      run_prog(1'b0);
      check("t2_halted", 32'(ifc.halted), 32'd1);
      check("t2_stat", 32'(ifc.stat), 32'd2);
      check("t2_icnt", 32'(ifc.instr_count), 32'd2);
      poke_go();

      // Illegal icode, and address error taking priority over it.
      do_reset();
      prog.push_back(mk(0, 1, 0, 0, 0));
      run_prog(1'b0);
      check("t3_ins_stat", 32'(ifc.stat), 32'd4);
      do_reset();
      prog.push_back(mk(1, 1, 1, 0, 0));
      run_prog(1'b0);
      check("t3_adr_stat", 32'(ifc.stat), 32'd3);

      // Memory stalls: short stall, last-cycle ready, and timeout.
      do_reset();
      prog.push_back(mk(0, 0, 0, 3, 0));
      run_prog(1'b0);
      check("t4_stall_ccnt", 32'(ifc.cycle_count), 32'd9);
      do_reset();
      prog.push_back(mk(0, 0, 0, 15, 0));
      run_prog(1'b0);
      check("t4_edge_icnt", 32'(ifc.instr_count), 32'd1);
      check("t4_edge_ccnt", 32'(ifc.cycle_count), 32'd21);
      do_reset();
      prog.push_back(mk(0, 0, 0, 16, 0));
      run_prog(1'b0);
      check("t4_tmo_stat", 32'(ifc.stat), 32'd3);
      check("t4_tmo_ccnt", 32'(ifc.cycle_count), 32'd19);

      // Data address error on completion.
      do_reset();
      prog.push_back(mk(0, 0, 0, 1, 1));
      run_prog(1'b0);
      check("t5_stat", 32'(ifc.stat), 32'd3);
      check("t5_icnt", 32'(ifc.instr_count), 32'd0);

      // Single-step: one instruction per go.
      do_reset();
      prog.push_back(mk(0, 0, 0, 0, 0));
      prog.push_back(mk(0, 0, 0, 2, 0));
      run_prog(1'b1);
      check("t6_icnt", 32'(ifc.instr_count), 32'd2);

      // Reset while waiting in MEMORY.
      do_reset();
      mon_en        = 1'b0;
      ifc.mem_ready = 1'b0;
      ifc.go        = 1'b1;
      cyc           = 0;
      do begin
         @(negedge clk);
         #1;
         ifc.go        = 1'b0;
         ifc.mem_ready = 1'b0;
         cyc++;
      end while (!ifc.memory_en && (cyc < 20));
      check("t7_in_memory", 32'(ifc.memory_en), 32'd1);
      repeat (2) begin
         @(negedge clk);
         #1;
      end
      check("t7_still_memory", 32'(ifc.memory_en), 32'd1);
      do_reset();

      // Long run: instr_count wraps and cycle_count saturates.
      for (int k = 0; k < 300; k++) begin
         prog.push_back(mk(0, 0, 0, int'($urandom_range(0, 1)), 0));
      end
      run_prog(1'b0);
      check("t8_icnt_wrap", 32'(ifc.instr_count), 32'd44);
      check("t8_ccnt_sat", 32'(ifc.cycle_count), 32'd255);

      // Randomized programs.
      for (int r = 0; r < 12; r++) begin
         do_reset();
         n = int'($urandom_range(1, 6));
         for (int k = 0; k < n; k++) begin
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 2));
            prog.push_back(mk($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                              $urandom_range(0, 11) == 0, st, $urandom_range(0, 14) == 0));
         end
         run_prog(1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
